// File: rtl/imm_ext_bus.sv
// Clocked immediate extension unit that drives its holding register onto a split tri-state bus.
// Optional macro IMM_EXT_SHIFT_EN enables word-shifted jump/branch immediates (modes 011 and 110).
module imm_ext_bus #(
    parameter int DW    = 32,
    parameter int IW    = 32,
    parameter int SPLIT = 28
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ld,
    input  logic [IW-1:0]       i_instr,
    input  logic [2:0]          i_mode,
    input  logic                i_oe_h,
    input  logic                i_oe_l,
    input  logic                i_seq_start,
    output logic [DW-SPLIT-1:0] o_bus_h,
    output logic [SPLIT-1:0]    o_bus_l,
    output logic [DW-1:0]       o_imm_out,
    output logic                o_imm_valid,
    output logic                o_seq_busy,
    output logic                o_seq_done
);

    localparam int HW = DW - SPLIT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEQ_H = 2'd1;
    localparam logic [1:0] S_SEQ_L = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Bits above the source field are sign- or zero-filled out to the full data width.
    function automatic logic [DW-1:0] f_extend(input logic [IW-1:0] instr, input logic [2:0] mode);
        logic [15:0]   imm16;
        logic [25:0]   imm26;
        logic [DW-1:0] sx16;
        logic [DW-1:0] zx16;
        logic [DW-1:0] zx26;
        logic [DW-1:0] res;
        imm16 = instr[15:0];
        imm26 = instr[25:0];
        sx16  = DW'($signed(imm16));
        zx16  = DW'(imm16);
        zx26  = DW'(imm26);
        case (mode)
            3'b000:  res = sx16;
            3'b001:  res = zx16;
            3'b010:  res = DW'(1'b1);
`ifdef IMM_EXT_SHIFT_EN
            3'b011:  res = zx26 << 2'd2;
            3'b110:  res = sx16 << 2'd2;
`else
            3'b011:  res = zx26;
`endif
            3'b100:  res = sx16 << 5'd16;
            default: res = sx16;
        endcase
        return res;
    endfunction

    logic [DW-1:0] r_imm;
    logic          r_valid;
    logic [1:0]    r_state;
    logic          r_drive_h;
    logic          r_drive_l;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic          w_ld_ok;
    logic [DW-1:0] w_imm_nxt;

    // Loads are locked out for the whole sequence so both beats carry the same value.
    assign w_ld_ok   = i_ld & (r_state == S_IDLE);
    assign w_imm_nxt = f_extend(i_instr, i_mode);

    // Sequencer next-state decode; a same-cycle load takes priority over a start request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_seq_start & r_valid & ~i_ld) begin
                    w_state_nxt = S_SEQ_H;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEQ_H: w_state_nxt = S_SEQ_L;
            S_SEQ_L: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Holding register and its valid flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_imm   <= {DW{1'b0}};
            r_valid <= 1'b0;
        end else if (w_ld_ok) begin
            r_imm   <= w_imm_nxt;
            r_valid <= 1'b1;
        end else begin
            r_imm   <= r_imm;
            r_valid <= r_valid;
        end
    end

    // State plus status/enable flags, registered from the next state so they align with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drive_h <= 1'b0;
            r_drive_l <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_drive_h <= i_oe_h | (w_state_nxt == S_SEQ_H);
            r_drive_l <= i_oe_l | (w_state_nxt == S_SEQ_L);
        end
    end

    assign o_bus_h     = r_drive_h ? r_imm[DW-1:SPLIT] : {HW{1'bz}};
    assign o_bus_l     = r_drive_l ? r_imm[SPLIT-1:0]  : {SPLIT{1'bz}};
    assign o_imm_out   = r_imm;
    assign o_imm_valid = r_valid;
    assign o_seq_busy  = r_busy;
    assign o_seq_done  = r_done;

endmodule

// File: tb/tb_imm_ext_bus.sv
// Table-driven bench for imm_ext_bus with a scoreboard queue of expected immediates.
`timescale 1ns/1ps
module tb_imm_ext_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [31:0] instr;
    logic [2:0]  mode;
    logic        oe_h;
    logic        oe_l;
    logic        seq_start;
    logic [3:0]  bus_h;
    logic [27:0] bus_l;
    logic [31:0] imm_out;
    logic        imm_valid;
    logic        seq_busy;
    logic        seq_done;

    imm_ext_bus #(.DW(32), .IW(32), .SPLIT(28)) dut (
        .i_clk(clk), .i_rst(rst), .i_ld(ld), .i_instr(instr), .i_mode(mode),
        .i_oe_h(oe_h), .i_oe_l(oe_l), .i_seq_start(seq_start),
        .o_bus_h(bus_h), .o_bus_l(bus_l), .o_imm_out(imm_out),
        .o_imm_valid(imm_valid), .o_seq_busy(seq_busy), .o_seq_done(seq_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_imm;
    logic [31:0] seq_imm;
    logic [3:0]  zh = 4'bzzzz;
    logic [27:0] zl = {28{1'bz}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] ins, input logic [2:0] md, input logic [31:0] ex);
        ld    = 1'b1;
        instr = ins;
        mode  = md;
        sb.push_back(ex);
        step();
        ld = 1'b0;
        chk("imm_out", {32'h0, imm_out}, {32'h0, sb.pop_front()});
        chk("imm_valid", {63'h0, imm_valid}, 64'h1);
        cur_imm = ex;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_8001, 3'b000, 32'hFFFF_8001};
        vecs[1]  = '{32'h0000_8001, 3'b001, 32'h0000_8001};
        vecs[2]  = '{32'h0000_8001, 3'b010, 32'h0000_0001};
        vecs[3]  = '{32'h0000_8001, 3'b100, 32'h8001_0000};
        vecs[4]  = '{32'h0000_8001, 3'b101, 32'hFFFF_8001};
        vecs[5]  = '{32'h0000_8001, 3'b111, 32'hFFFF_8001};
        vecs[6]  = '{32'h0123_4567, 3'b000, 32'h0000_4567};
        vecs[7]  = '{32'h0123_4567, 3'b100, 32'h4567_0000};
        vecs[8]  = '{32'hFFFF_FFFF, 3'b001, 32'h0000_FFFF};
`ifdef IMM_EXT_SHIFT_EN
        vecs[9]  = '{32'h0000_8001, 3'b011, 32'h0002_0004};
        vecs[10] = '{32'h0000_8001, 3'b110, 32'hFFFE_0004};
        vecs[11] = '{32'h0000_FFFF, 3'b110, 32'hFFFF_FFFC};
        vecs[12] = '{32'h0000_FFFF, 3'b011, 32'h0003_FFFC};
        vecs[13] = '{32'hFFFF_FFFF, 3'b011, 32'h0FFF_FFFC};
        seq_imm  = 32'h048D_159C;
`else
        vecs[9]  = '{32'h0000_8001, 3'b011, 32'h0000_8001};
        vecs[10] = '{32'h0000_8001, 3'b110, 32'hFFFF_8001};
        vecs[11] = '{32'h0000_FFFF, 3'b110, 32'hFFFF_FFFF};
        vecs[12] = '{32'h0000_FFFF, 3'b011, 32'h0000_FFFF};
        vecs[13] = '{32'hFFFF_FFFF, 3'b011, 32'h03FF_FFFF};
        seq_imm  = 32'h0123_4567;
`endif

        rst = 1'b1; ld = 1'b0; instr = 32'h0; mode = 3'b000;
        oe_h = 1'b0; oe_l = 1'b0; seq_start = 1'b0;
        step();
        step();
        chk("rst_imm", {32'h0, imm_out}, 64'h0);
        chk("rst_valid", {63'h0, imm_valid}, 64'h0);
        chk("rst_busy", {63'h0, seq_busy}, 64'h0);
        chk("rst_done", {63'h0, seq_done}, 64'h0);
        chk("rst_bus_h", {60'h0, bus_h}, {60'h0, zh});
        chk("rst_bus_l", {36'h0, bus_l}, {36'h0, zl});
        rst = 1'b0;
        step();

        // Start request with nothing loaded must be ignored.
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        chk("novalid_busy", {63'h0, seq_busy}, 64'h0);
        chk("novalid_bus_h", {60'h0, bus_h}, {60'h0, zh});
        step();
        chk("novalid_done", {63'h0, seq_done}, 64'h0);

        for (int i = 0; i < 14; i++) begin
            load(vecs[i].instr, vecs[i].mode, vecs[i].exp);
        end

        // Manual drive of each segment, then both together.
        load(32'h0000_8001, 3'b000, 32'hFFFF_8001);
        oe_h = 1'b1;
        step();
        oe_h = 1'b0;
        chk("man_bus_h", {60'h0, bus_h}, 64'hF);
        chk("man_bus_l_z", {36'h0, bus_l}, {36'h0, zl});
        oe_l = 1'b1;
        step();
        oe_l = 1'b0;
        chk("man_bus_h_z", {60'h0, bus_h}, {60'h0, zh});
        chk("man_bus_l", {36'h0, bus_l}, 64'hFFF_8001);
        oe_h = 1'b1; oe_l = 1'b1;
        step();
        oe_h = 1'b0; oe_l = 1'b0;
        chk("both_bus_h", {60'h0, bus_h}, 64'hF);
        chk("both_bus_l", {36'h0, bus_l}, 64'hFFF_8001);
        step();
        chk("off_bus_l", {36'h0, bus_l}, {36'h0, zl});

        // Two-beat sequence with a blocked load and a blocked restart during SEQ_L.
        load(32'h0123_4567, 3'b011, seq_imm);
        seq_start = 1'b1;
        step();
        seq_start = 1'b0;
        chk("seqh_busy", {63'h0, seq_busy}, 64'h1);
        chk("seqh_bus_h", {60'h0, bus_h}, {60'h0, seq_imm[31:28]});
        chk("seqh_bus_l", {36'h0, bus_l}, {36'h0, zl});
        chk("seqh_done", {63'h0, seq_done}, 64'h0);
        step();
        chk("seql_busy", {63'h0, seq_busy}, 64'h1);
        chk("seql_bus_l", {36'h0, bus_l}, {36'h0, seq_imm[27:0]});
        chk("seql_bus_h", {60'h0, bus_h}, {60'h0, zh});
        ld = 1'b1; instr = 32'hFFFF_FFFF; mode = 3'b001; seq_start = 1'b1;
        step();
        ld = 1'b0; seq_start = 1'b0;
        chk("done_pulse", {63'h0, seq_done}, 64'h1);
        chk("done_busy", {63'h0, seq_busy}, 64'h1);
        chk("done_bus_h", {60'h0, bus_h}, {60'h0, zh});
        chk("done_bus_l", {36'h0, bus_l}, {36'h0, zl});
        chk("ld_blocked", {32'h0, imm_out}, {32'h0, cur_imm});
        step();
        chk("idle_busy", {63'h0, seq_busy}, 64'h0);
        chk("idle_done", {63'h0, seq_done}, 64'h0);
        step();
        chk("noqueue_busy", {63'h0, seq_busy}, 64'h0);

        // Load and start in the same idle cycle: the load wins.
        seq_start = 1'b1;
        load(32'h0000_FFFF, 3'b001, 32'h0000_FFFF);
        seq_start = 1'b0;
        chk("ldstart_busy", {63'h0, seq_busy}, 64'h0);
        step();
        chk("ldstart_busy2", {63'h0, seq_busy}, 64'h0);

        // Manual low enable overlapping sequencer high beat drives both segments.
        seq_start = 1'b1; oe_l = 1'b1;
        step();
        seq_start = 1'b0; oe_l = 1'b0;
        chk("or_bus_h", {60'h0, bus_h}, 64'h0);
        chk("or_bus_l", {36'h0, bus_l}, 64'h000_FFFF);

        // Asynchronous reset during SEQ_H, checked before the next clock edge.
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", {63'h0, seq_busy}, 64'h0);
        chk("arst_done", {63'h0, seq_done}, 64'h0);
        chk("arst_valid", {63'h0, imm_valid}, 64'h0);
        chk("arst_imm", {32'h0, imm_out}, 64'h0);
        chk("arst_bus_h", {60'h0, bus_h}, {60'h0, zh});
        chk("arst_bus_l", {36'h0, bus_l}, {36'h0, zl});
        step();
        rst = 1'b0;
        step();
        chk("post_rst_done", {63'h0, seq_done}, 64'h0);
        chk("post_rst_busy", {63'h0, seq_busy}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_ext_bus.md
Name: imm_ext_bus

Overview:
- Parametrised, clocked successor to the multi-cycle CPU's sign-extension/immediate unit.
- Captures an instruction word on a load strobe and builds the extended immediate for a selected mode in a holding register.
- Drives the register onto the shared datapath bus as two tri-stated segments (high/low).
- Segments are driven either by level-sampled output enables or by a built-in two-beat sequencer for narrow-bus transfers.

Parameters:
- DW, 32, immediate/bus data width
- IW, 32, instruction width; must be >= 26
- SPLIT, 28, width of low segment; high segment is DW-SPLIT bits; 1 <= SPLIT <= DW-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld  in  1  capture instr/mode this edge
- instr  in  IW  instruction word
- mode  in  3  extension mode
- oe_h  in  1  request drive of high segment
- oe_l  in  1  request drive of low segment
- seq_start  in  1  start two-beat sequenced drive
- bus_h  out  DW-SPLIT  high segment, tri-state
- bus_l  out  SPLIT  low segment, tri-state
- imm_out  out  DW  holding register, always driven
- imm_valid  out  1  holding register holds a loaded value
- seq_busy  out  1  sequencer active
- seq_done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset (async, rst=1), all values hold while rst high:
  - imm_reg=0, imm_valid=0, oe_h_q=oe_l_q=0, state=IDLE
  - seq_busy=0, seq_done=0, bus_h/bus_l = all Z
- Mode decode (from instr at the ld edge; imm16=instr[15:0], imm26=instr[25:0]):
  - 000 sign-extend imm16 to DW
  - 001 zero-extend imm16
  - 010 constant 1
  - 011 zero-extend imm26
  - 100 imm16 placed in bits [31:16], low 16 bits zero; bits above 31 sign-filled when DW>32
  - 101..111 treated as 000
- Load timing:
  - ld sampled high → imm_reg updated at that edge; imm_valid=1 from that edge onward.
  - imm_out = imm_reg, so latency is 1 clock.
- Load gating:
  - ld while seq_busy=1 is ignored; imm_reg stays stable for the whole sequence.
  - ld and seq_start high in the same IDLE cycle: the load wins; seq_start is ignored that cycle.
- Manual drive:
  - oe_h/oe_l are registered each edge into oe_h_q/oe_l_q.
  - bus_h = imm_reg[DW-1:SPLIT] when drive_h, else Z; drive_h = oe_h_q | (state==SEQ_H).
  - bus_l = imm_reg[SPLIT-1:0] when drive_l, else Z; drive_l = oe_l_q | (state==SEQ_L).
  - Enable → drive latency is 1 clock; deassert → Z latency is 1 clock.
  - Level-sensitive only; no edge-triggered drivers.
- Sequencer FSM (IDLE, SEQ_H, SEQ_L, DONE):
  - IDLE → SEQ_H when seq_start & imm_valid & !ld; seq_start with imm_valid=0 is ignored.
  - SEQ_H → SEQ_L unconditionally after 1 cycle.
  - SEQ_L → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle; seq_done=1 only in DONE.
  - seq_busy=1 in SEQ_H, SEQ_L and DONE.
  - seq_start while busy is ignored (no queueing).
- Simultaneous events:
  - Manual oe and sequencer drive of the same segment are ORed, not a conflict.
  - Both segments may be driven in the same cycle.
- Reset mid-sequence: state→IDLE, buses Z, seq_done not asserted, imm_valid cleared.

Optional Feature:
- Macro IMM_EXT_SHIFT_EN.
- Defined:
  - mode 011 yields zero-extended imm26 << 2 (requires DW >= 28).
  - New mode 110 yields sign-extended imm16 << 2 (branch offset).
  - 111 is still treated as 000.
- Undefined: no shifting in any mode; 110 and 111 are treated as 000.

Test Plan:
- Reset/idle: assert rst mid-run → bus_h/bus_l = Z, imm_out=0, imm_valid=0, seq_busy=0 immediately, without waiting for a clock edge.
- Extension modes: ld with instr=32'h0000_8001, each mode in turn (DW=32) → imm_out, one cycle later:
  - 000: FFFF_8001
  - 001: 0000_8001
  - 010: 0000_0001
  - 011: 0000_8001
  - 100: 8001_0000
- Manual drive: load FFFF_8001 (mode 000), oe_h=1 for one cycle → next cycle bus_h=4'hF, bus_l=Z; then oe_l=1 → bus_l=28'hFFF_8001.
- Sequencer: load instr=32'h0123_4567 with mode 011 → imm 0123_4567; pulse seq_start → busy 3 cycles, with:
  - SEQ_H: bus_h=4'h0, bus_l=Z
  - SEQ_L: bus_l=28'h123_4567, bus_h=Z
  - DONE: seq_done=1, both buses Z
  - Also check: seq_start with imm_valid=0 → no activity.
- Hazards:
  - ld during SEQ_L → imm_out unchanged.
  - ld+seq_start in the same IDLE cycle → load happens, seq_busy stays 0.
  - rst during SEQ_H → IDLE, no seq_done.
- IMM_EXT_SHIFT_EN: instr=32'h0000_FFFF, mode 110 → FFFF_FFFC; mode 011 → 0003_FFFC. Without the macro, mode 110 → FFFF_FFFF.
